fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4: prefetch FIFO entries; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0: first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low; asserts immediately, releases synchronously to clk.
REQ-005 redirect  input  1  load new fetch PC and flush (branch/jump from execute).
REQ-006 redirect_pc  input  32  new fetch PC; bits [1:0] ignored.
REQ-007 rom_en  output  1  ROM read request this cycle.
REQ-008 rom_addr  output  7  ROM word address, fetch_pc[8:2].
REQ-009 rom_data  input  32  ROM read data, valid the cycle after rom_en.
REQ-010 insn_valid  output  1  insn/insn_pc hold a valid instruction.
REQ-011 insn_ready  input  1  decode stage accepts insn this cycle.
REQ-012 insn  output  32  instruction word at FIFO head.
REQ-013 insn_pc  output  32  byte address of insn.

Function
REQ-014 Handshake: transfer when insn_valid && insn_ready; insn_valid, once high, stays high with insn/insn_pc stable until transfer or redirect.
REQ-015 FSM states IDLE, RUN, WAIT; IDLE -> RUN first cycle after reset release; RUN -> WAIT when count + inflight == DEPTH; WAIT -> RUN when space frees; any state -> RUN on redirect.
REQ-016 rom_en high only in RUN with count + inflight < DEPTH; in IDLE and WAIT, rom_en is 0.
REQ-017 inflight: 1-bit flag, set on the rom_en cycle, cleared the next cycle; at most one outstanding read.
REQ-018 On each issued request, fetch_pc <= fetch_pc + 4, modulo 2^32; rom_addr wraps 127 -> 0 with no special handling.
REQ-019 Response cycle: {rom_data, request PC} written to FIFO tail unless discarded (REQ-021).
REQ-020 Base latency: rom_en in cycle N, FIFO empty -> insn_valid in cycle N+2.
REQ-021 redirect: fetch_pc <= {redirect_pc[31:2],2'b00}, FIFO emptied, any response arriving the next cycle discarded; insn_valid low the cycle after redirect; rom_en in the redirect cycle is 0.
REQ-022 redirect simultaneous with transfer: transfer completes for the consumer, then flush applies; redirect wins over FIFO write in the same cycle.
REQ-023 Full FIFO with simultaneous read and write: both occur, count unchanged.
REQ-024 Empty FIFO: insn_valid 0, insn/insn_pc hold last value (don't-care to consumer).
REQ-025 Steady state with insn_ready held high: one instruction per cycle after fill (requires DEPTH >= 2).

Reset
REQ-026 While rst low: FSM IDLE, fetch_pc = RESET_PC, FIFO empty, inflight 0, rom_en 0, insn_valid 0, insn 0, insn_pc 0.
REQ-027 Reset mid-operation discards all FIFO contents and the in-flight response; no response arriving during or after reset reaches the FIFO.

Configuration
REQ-028 Macro FETCH_BYPASS_EN defined: when FIFO empty and response valid (not discarded), rom_data/PC drive insn/insn_pc combinationally with insn_valid 1 that cycle; if insn_ready is 1 the entry is not written, otherwise it is written to FIFO; latency N+1.
REQ-029 FETCH_BYPASS_EN undefined: no combinational path from rom_data to insn; latency per REQ-020.

Verification
REQ-030 Release reset, insn_ready=1, ROM word k = k -> rom_addr 0,1,2,...; insn 0,1,2,... with insn_pc 0,4,8; first insn_valid 3 cycles after release (2 with FETCH_BYPASS_EN).
REQ-031 insn_ready=0 for 10 cycles -> exactly DEPTH entries buffered, rom_en 0 while in WAIT; raise ready -> 4 words delivered in order, no loss/duplication.
REQ-032 redirect with redirect_pc=32'h40 while request in flight -> stale response dropped; next delivered insn_pc 32'h40, insn = ROM word 16.
REQ-033 redirect and transfer in same cycle -> transferred word counted once; next delivered insn_pc = redirect target.
REQ-034 fetch_pc 32'h1FC -> rom_addr 127 then 0; insn_pc 32'h1FC then 32'h200.
REQ-035 rst low asynchronously mid-stream with FIFO full -> outputs reach reset values without clock edge; after release restart from RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- instruction prefetch unit.
//
// Issues sequential ROM reads and buffers the returned words, each with its
// byte address, in a small prefetch FIFO. The FIFO head is presented to the
// decode stage.
//
// Handshake: a word transfers to decode on a rising edge where insn_valid and
// insn_ready are both high. Once insn_valid is high, insn/insn_pc stay stable
// until that transfer happens or a redirect flushes the FIFO.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous, active-low reset
//   redirect     load redirect_pc as the new fetch PC and flush the FIFO
//   redirect_pc  new fetch PC (bits [1:0] ignored)
//   rom_en       ROM read request this cycle
//   rom_addr     ROM word address, fetch_pc[8:2]
//   rom_data     ROM read data, valid the cycle after rom_en
//   insn_valid   insn/insn_pc hold a valid instruction
//   insn_ready   decode accepts insn this cycle
//   insn         instruction word at FIFO head
//   insn_pc      byte address of insn
//   dbg_state    current FSM state (0 IDLE, 1 RUN, 2 WAIT)
//
// Optional build macro FETCH_BYPASS_EN: when the FIFO is empty, a ROM
// response drives insn/insn_pc combinationally in the same cycle and is only
// written to the FIFO if decode does not take it immediately.
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        rom_en,
  output logic [6:0]  rom_addr,
  input  logic [31:0] rom_data,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [31:0] insn,
  output logic [31:0] insn_pc,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;     // PC of the outstanding read
  logic          inflight;
  logic [31:0]   mem_data [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, occ;
  logic          resp_valid, fifo_empty, bypass, xfer, fifo_wr, fifo_rd;
  logic          unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Occupancy counts the outstanding read so the FIFO can never overflow.
  assign occ        = count + CW'(inflight);
  assign fifo_empty = (count == '0);
  // A response landing in a redirect cycle belongs to the old stream.
  assign resp_valid = inflight && !redirect;
  assign rom_addr   = fetch_pc[8:2];
  assign dbg_state  = state;

`ifdef FETCH_BYPASS_EN
  assign bypass     = fifo_empty && resp_valid;
  assign insn       = bypass ? rom_data : mem_data[rd_ptr];
  assign insn_pc    = bypass ? req_pc   : mem_pc[rd_ptr];
`else
  assign bypass     = 1'b0;
  assign insn       = mem_data[rd_ptr];
  assign insn_pc    = mem_pc[rd_ptr];
`endif

  assign insn_valid = !fifo_empty || bypass;
  assign xfer       = insn_valid && insn_ready;
  assign fifo_rd    = xfer && !fifo_empty;
  // A bypassed word taken by decode the same cycle never enters the FIFO.
  assign fifo_wr    = resp_valid && !(bypass && insn_ready);

  always_comb begin
    state_nxt = state;
    rom_en    = 1'b0;
    case (state)
      IDLE: state_nxt = RUN;
      RUN: begin
        rom_en = (occ < CW'(DEPTH));
        if (occ == CW'(DEPTH)) state_nxt = WAIT;
      end
      WAIT: if (occ < CW'(DEPTH)) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (redirect) begin
      state_nxt = RUN;
      rom_en    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_data[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else begin
      state    <= state_nxt;
      inflight <= rom_en;
      if (redirect)    fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (rom_en) fetch_pc <= fetch_pc + 32'd4;
      if (rom_en) req_pc <= fetch_pc;

      if (redirect) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (fifo_wr) begin
          mem_data[wr_ptr] <= rom_data;
          mem_pc[wr_ptr]   <= req_pc;
          wr_ptr           <= wr_ptr + AW'(1);
        end
        if (fifo_rd) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(fifo_wr) - CW'(fifo_rd);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit -- self-checking bench for fetch_unit.
// ROM word k holds the value k. The reference model is the ordered stream of
// byte addresses decode must see: sequential from the reset PC or from the
// last redirect target, each paired with ROM word pc[8:2].
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_WAIT  = 2'd2;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        rom_en;
  logic [6:0]  rom_addr;
  logic [31:0] rom_data = '0;
  logic        insn_valid;
  logic        insn_ready = 1'b0;
  logic [31:0] insn, insn_pc;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rp;

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .insn_valid(insn_valid), .insn_ready(insn_ready), .insn(insn),
    .insn_pc(insn_pc), .dbg_state(dbg_state)
  );

  // ROM: word k = k, one cycle latency; garbage when no read was issued.
  always @(posedge clk) rom_data <= rom_en ? {25'd0, rom_addr} : $urandom();

  // One cycle: drive inputs just after the edge, observe at the falling edge.
  task automatic step(input logic rd, input logic rdy, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    redirect    = rd;
    insn_ready  = rdy;
    redirect_pc = rpc;
    @(negedge clk);
  endtask

  task automatic sb_restart(input logic [31:0] pc);
    logic [31:0] base;
    base = {pc[31:2], 2'b00};
    exp_q.delete();
    for (int i = 0; i < 500; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL reset_rom_en: got %b expected 0", rom_en); end
    n_checks++; if (insn_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", insn_valid); end
    n_checks++; if (insn !== 32'd0) begin n_fail++; $display("FAIL reset_insn: got %h expected 0", insn); end
    n_checks++; if (insn_pc !== 32'd0) begin n_fail++; $display("FAIL reset_insn_pc: got %h expected 0", insn_pc); end
    n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    n_checks++; if (rom_addr !== rp[8:2]) begin n_fail++; $display("FAIL reset_rom_addr: got %0d expected %0d", rom_addr, rp[8:2]); end
  endtask

  task automatic test_first_fetch();
    int first_c = -1;
    int n_x = 0;
    logic [6:0] exp_addr;
    logic [31:0] e;
    sb_restart(RESET_PC);
    exp_addr = rp[8:2];
    @(posedge clk); #1; rst = 1'b1; insn_ready = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      if (c > 0) step(1'b0, 1'b1, 32'd0);
      if (insn_valid && first_c < 0) first_c = c;
      if (rom_en) begin
        n_checks++;
        if (rom_addr !== exp_addr) begin n_fail++; $display("FAIL first_rom_addr: got %0d expected %0d", rom_addr, exp_addr); end
        exp_addr++;
      end
      if (insn_valid && insn_ready) begin
        n_x++;
        n_checks++;
        e = exp_q.pop_front();
        if (insn_pc !== e || insn !== {25'd0, e[8:2]}) begin
          n_fail++; $display("FAIL first_data: got pc %h insn %h expected pc %h insn %h", insn_pc, insn, e, {25'd0, e[8:2]});
        end
      end
    end
    n_checks++; if (first_c != LAT) begin n_fail++; $display("FAIL first_latency: got %0d expected %0d", first_c, LAT); end
    n_checks++; if (n_x != 20 - LAT) begin n_fail++; $display("FAIL steady_rate: got %0d transfers expected %0d", n_x, 20 - LAT); end
  endtask

  task automatic test_stall();
    logic [31:0] tgt, e;
    int issued = 0;
    tgt = $urandom();
    step(1'b1, 1'b0, tgt);
    sb_restart(tgt);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 32'd0);
      if (rom_en) issued++;
      if (dbg_state == ST_WAIT) begin
        n_checks++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL stall_rom_en_wait: got %b expected 0", rom_en); end
      end
    end
    n_checks++; if (issued != DEPTH) begin n_fail++; $display("FAIL stall_buffered: got %0d expected %0d", issued, DEPTH); end
    n_checks++; if (dbg_state !== ST_WAIT) begin n_fail++; $display("FAIL stall_state: got %0d expected %0d", dbg_state, ST_WAIT); end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 32'd0);
      n_checks++;
      if (insn_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_drain_valid: word %0d got %b expected 1", i, insn_valid);
      end else begin
        e = exp_q.pop_front();
        if (insn_pc !== e || insn !== {25'd0, e[8:2]}) begin
          n_fail++; $display("FAIL stall_drain_data: got pc %h insn %h expected pc %h insn %h", insn_pc, insn, e, {25'd0, e[8:2]});
        end
      end
    end
  endtask

  task automatic test_redirect_inflight();
    logic [31:0] e;
    logic found = 1'b0;
    logic got = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 1'b1, 32'd0);
      if (insn_valid && insn_ready) begin
        n_checks++;
        e = exp_q.pop_front();
        if (insn_pc !== e || insn !== {25'd0, e[8:2]}) begin
          n_fail++; $display("FAIL redir_pre_data: got pc %h insn %h expected pc %h", insn_pc, insn, e);
        end
      end
      if (rom_en) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL redir_find_req: got no rom_en expected one within 10 cycles"); end
    step(1'b1, 1'b0, 32'h40 | 32'($urandom_range(0, 3)));
    sb_restart(32'h40);
    n_checks++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL redir_rom_en: got %b expected 0", rom_en); end
    step(1'b0, 1'b1, 32'd0);
    n_checks++; if (insn_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid_after: got %b expected 0", insn_valid); end
    for (int i = 0; i < 20 && !got; i++) begin
      if (i > 0) step(1'b0, 1'b1, 32'd0);
      if (insn_valid) begin
        got = 1'b1;
        n_checks++;
        e = exp_q.pop_front();
        if (insn_pc !== 32'h40 || insn !== 32'd16) begin
          n_fail++; $display("FAIL redir_first: got pc %h insn %h expected pc 00000040 insn 00000010", insn_pc, insn);
        end
      end
    end
    n_checks++; if (!got) begin n_fail++; $display("FAIL redir_timeout: got no insn expected one within 20 cycles"); end
  endtask

  task automatic test_redirect_xfer();
    logic [31:0] tgt, e;
    logic got = 1'b0;
    repeat (6) step(1'b0, 1'b0, 32'd0);
    tgt = $urandom();
    step(1'b1, 1'b1, tgt);
    n_checks++;
    if (insn_valid !== 1'b1) begin
      n_fail++; $display("FAIL rx_valid: got %b expected 1", insn_valid);
    end else begin
      e = exp_q.pop_front();
      if (insn_pc !== e || insn !== {25'd0, e[8:2]}) begin
        n_fail++; $display("FAIL rx_data: got pc %h insn %h expected pc %h", insn_pc, insn, e);
      end
    end
    sb_restart(tgt);
    step(1'b0, 1'b1, 32'd0);
    n_checks++; if (insn_valid !== 1'b0) begin n_fail++; $display("FAIL rx_valid_after: got %b expected 0", insn_valid); end
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b0, 1'b1, 32'd0);
      if (insn_valid) begin
        got = 1'b1;
        n_checks++;
        e = exp_q.pop_front();
        if (insn_pc !== {tgt[31:2], 2'b00} || insn !== {25'd0, tgt[8:2]}) begin
          n_fail++; $display("FAIL rx_next: got pc %h insn %h expected pc %h", insn_pc, insn, {tgt[31:2], 2'b00});
        end
      end
    end
    n_checks++; if (!got) begin n_fail++; $display("FAIL rx_timeout: got no insn expected one within 20 cycles"); end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    logic [31:0] pcs[$];
    logic [6:0] exp_addr = 7'd127;
    step(1'b1, 1'b0, 32'h1FC);
    sb_restart(32'h1FC);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 32'd0);
      if (rom_en) begin
        n_checks++;
        if (rom_addr !== exp_addr) begin n_fail++; $display("FAIL wrap_rom_addr: got %0d expected %0d", rom_addr, exp_addr); end
        exp_addr++;
      end
      if (insn_valid && insn_ready) begin
        pcs.push_back(insn_pc);
        n_checks++;
        e = exp_q.pop_front();
        if (insn_pc !== e || insn !== {25'd0, e[8:2]}) begin
          n_fail++; $display("FAIL wrap_data: got pc %h insn %h expected pc %h insn %h", insn_pc, insn, e, {25'd0, e[8:2]});
        end
      end
    end
    n_checks++;
    if (pcs.size() < 2 || pcs[0] !== 32'h1FC || pcs[1] !== 32'h200) begin
      n_fail++; $display("FAIL wrap_pcs: got %0d transfers expected pc 000001fc then 00000200", pcs.size());
    end
  endtask

  task automatic test_random();
    logic rd, rdy, p_rd = 1'b0, p_rdy = 1'b1, p_valid = 1'b0;
    logic [31:0] rpc, e, p_insn = '0, p_pc = '0;
    for (int i = 0; i < 400; i++) begin
      rd  = ($urandom_range(0, 99) < 4);
      rdy = ($urandom_range(0, 99) < 70);
      rpc = $urandom();
      step(rd, rdy, rpc);
      if (p_rd) begin
        n_checks++; if (insn_valid !== 1'b0) begin n_fail++; $display("FAIL rand_valid_after_redirect: got %b expected 0", insn_valid); end
      end else if (p_valid && !p_rdy) begin
        n_checks++;
        if (insn_valid !== 1'b1 || insn !== p_insn || insn_pc !== p_pc) begin
          n_fail++; $display("FAIL rand_hold: got v %b pc %h insn %h expected v 1 pc %h insn %h", insn_valid, insn_pc, insn, p_pc, p_insn);
        end
      end
      if (insn_valid && insn_ready) begin
        n_checks++;
        e = exp_q.pop_front();
        if (insn_pc !== e || insn !== {25'd0, e[8:2]}) begin
          n_fail++; $display("FAIL rand_data: cycle %0d got pc %h insn %h expected pc %h insn %h", i, insn_pc, insn, e, {25'd0, e[8:2]});
        end
      end
      if (rd) sb_restart(rpc);
      p_rd = rd; p_rdy = rdy; p_valid = insn_valid; p_insn = insn; p_pc = insn_pc;
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] e;
    int first_c = -1;
    repeat (10) step(1'b0, 1'b0, 32'd0);
    n_checks++; if (insn_valid !== 1'b1) begin n_fail++; $display("FAIL ar_full_valid: got %b expected 1", insn_valid); end
    @(posedge clk); #3; rst = 1'b0; #1;
    n_checks++; if (insn_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b expected 0", insn_valid); end
    n_checks++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL ar_rom_en: got %b expected 0", rom_en); end
    n_checks++; if (insn !== 32'd0 || insn_pc !== 32'd0) begin n_fail++; $display("FAIL ar_insn: got insn %h pc %h expected 0 0", insn, insn_pc); end
    n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL ar_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    n_checks++; if (rom_addr !== rp[8:2]) begin n_fail++; $display("FAIL ar_rom_addr: got %0d expected %0d", rom_addr, rp[8:2]); end
    repeat (2) @(negedge clk);
    sb_restart(RESET_PC);
    @(posedge clk); #1; rst = 1'b1; insn_ready = 1'b1; redirect = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) step(1'b0, 1'b1, 32'd0);
      if (insn_valid && first_c < 0) first_c = c;
      if (insn_valid && insn_ready) begin
        n_checks++;
        e = exp_q.pop_front();
        if (insn_pc !== e || insn !== {25'd0, e[8:2]}) begin
          n_fail++; $display("FAIL ar_restart_data: got pc %h insn %h expected pc %h insn %h", insn_pc, insn, e, {25'd0, e[8:2]});
        end
      end
    end
    n_checks++; if (first_c != LAT) begin n_fail++; $display("FAIL ar_latency: got %0d expected %0d", first_c, LAT); end
  endtask

  initial begin
    rp = RESET_PC;
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_inflight();
    test_redirect_xfer();
    test_wrap();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
